// File: rtl/gpio_debounce_pkg.sv
// Shared definitions for the GPIO debouncer.
// Contents:
//   cnt_width()    - width of the per-pin stability counter
//   presc_width()  - width of the shared sample-tick prescaler
//   params_legal() - parameter sanity check used at elaboration
//   pin_state_e    - per-pin debounce state (derived from s2 vs o_gpio)
package gpio_debounce_pkg;

    typedef enum logic {
        PinIdle,     // synchronized input matches debounced output
        PinPending   // input differs, counting stable ticks
    } pin_state_e;

    function automatic int unsigned cnt_width(input int unsigned nstable);
        return (nstable < 1) ? 1 : $clog2(nstable + 1);
    endfunction

    function automatic int unsigned presc_width(input int unsigned prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

    function automatic bit params_legal(input int unsigned nin,
                                        input int unsigned prescale,
                                        input int unsigned nstable);
        return (nin >= 1) && (nin <= 16) && (prescale >= 1) && (nstable >= 1);
    endfunction

endpackage

// File: rtl/gpio_debounce_pin.sv
// Single-pin debouncer: 2-FF synchronizer, stability counter and debounced register.
// Ports:
//   i_clk     - clock
//   i_reset   - asynchronous active-high reset
//   i_pin     - raw asynchronous pad
//   i_tick    - shared sample tick from the top-level prescaler
//   o_gpio    - debounced value
//   o_accept  - combinational: o_gpio takes the synchronized value at the next edge
module gpio_debounce_pin
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned NSTABLE = 4,
    parameter bit          INITIAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_pin,
    input  logic i_tick,
    output logic o_gpio,
    output logic o_accept
);

    localparam int unsigned CW = cnt_width(NSTABLE);
    localparam logic [CW-1:0] CntLast = CW'(NSTABLE - 1);

    logic          s1_q, s2_q;
    logic          gpio_q, gpio_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;
    pin_state_e    state;

    always_comb begin
        cnt_d  = cnt_q;
        gpio_d = gpio_q;
        accept = 1'b0;
        state  = (s2_q == gpio_q) ? PinIdle : PinPending;
        unique case (state)
            // Any cycle of agreement cancels a partial count (glitch rejection).
            PinIdle: cnt_d = '0;
            PinPending: begin
                if (i_tick) begin
                    if (cnt_q == CntLast) begin
                        gpio_d = s2_q;
                        cnt_d  = '0;
                        accept = 1'b1;
                    end else if (cnt_q < CntLast) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            s1_q   <= INITIAL;
            s2_q   <= INITIAL;
            gpio_q <= INITIAL;
            cnt_q  <= '0;
        end else begin
            s1_q   <= i_pin;
            s2_q   <= s1_q;
            gpio_q <= gpio_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_gpio   = gpio_q;
    assign o_accept = accept;

endmodule

// File: rtl/gpio_debounce.sv
// Multi-pin GPIO input debouncer with a shared sample prescaler.
// Each pin must differ from its debounced value for NSTABLE consecutive sample
// ticks before the change is accepted.
// Configuration macro: GPIO_DEBOUNCE_EDGE_EN enables per-pin o_rise/o_fall pulses;
// without it both outputs are tied to 0.
// Ports:
//   i_clk     - clock
//   i_reset   - asynchronous active-high reset
//   i_pin     - raw asynchronous pads [NIN]
//   o_gpio    - debounced values [NIN]
//   o_changed - one-cycle pulse when any o_gpio bit changes
//   o_rise    - per-pin 0->1 pulse, aligned with o_changed [NIN]
//   o_fall    - per-pin 1->0 pulse, aligned with o_changed [NIN]
module gpio_debounce
    import gpio_debounce_pkg::*;
#(
    parameter int unsigned    NIN      = 16,
    parameter int unsigned    PRESCALE = 1000,
    parameter int unsigned    NSTABLE  = 4,
    parameter logic [NIN-1:0] INITIAL  = '0
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [NIN-1:0] i_pin,
    output logic [NIN-1:0] o_gpio,
    output logic           o_changed,
    output logic [NIN-1:0] o_rise,
    output logic [NIN-1:0] o_fall
);

    if (!params_legal(NIN, PRESCALE, NSTABLE)) begin : g_bad_params
        $error("gpio_debounce: illegal NIN/PRESCALE/NSTABLE");
    end

    localparam int unsigned PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] PreLast = PW'(PRESCALE - 1);

    logic [PW-1:0]  pre_q, pre_d;
    logic           tick;
    logic [NIN-1:0] accept;
    logic [NIN-1:0] gpio;
    logic           changed_q;

    // With PRESCALE=1 the counter stays at 0 and tick is permanently high.
    always_comb begin
        tick  = (pre_q == PreLast);
        pre_d = tick ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pre_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            changed_q <= |accept;
        end
    end

    for (genvar i = 0; i < NIN; i++) begin : g_pin
        gpio_debounce_pin #(
            .NSTABLE (NSTABLE),
            .INITIAL (INITIAL[i])
        ) u_pin (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_pin    (i_pin[i]),
            .i_tick   (tick),
            .o_gpio   (gpio[i]),
            .o_accept (accept[i])
        );
    end

`ifdef GPIO_DEBOUNCE_EDGE_EN
    logic [NIN-1:0] rise_q, fall_q;

    // An accepted pin always flips, so the old value alone gives the direction.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            rise_q <= accept & ~gpio;
            fall_q <= accept & gpio;
        end
    end

    assign o_rise = rise_q;
    assign o_fall = fall_q;
`else
    assign o_rise = '0;
    assign o_fall = '0;
`endif

    assign o_gpio    = gpio;
    assign o_changed = changed_q;

endmodule
